euler_step_sequencer: RTL

- Sequential driver that wraps the combinational float integrator (out = x*2^-10 + int_x).
- Holds the integrated state register and requests a derivative from the upstream derivative evaluator for each substep.
- Feeds the derivative and the current state into the integrator, then latches the integrator's sum back into state.
- Runs NSTEPS Euler substeps per start trigger; the integrator is its downstream neighbour and the state register closes the loop.

---
 rtl/euler_step_sequencer_if.sv | 27 ++
 rtl/euler_step_sequencer.sv | 117 +++++++++++
 2 files changed

// File: rtl/euler_step_sequencer_if.sv
// rtl/euler_step_sequencer_if.sv - derivative handshake and integrator operand/result bundle
interface euler_step_sequencer_if;
    logic        deriv_req;
    logic        deriv_valid;
    logic [31:0] deriv_in;
    logic [31:0] state_out;
    logic [31:0] integ_x;
    logic [31:0] integ_sum;

    modport master (
        output deriv_req,
        output state_out,
        output integ_x,
        input  deriv_valid,
        input  deriv_in,
        input  integ_sum
    );

    modport slave (
        input  deriv_req,
        input  state_out,
        input  integ_x,
        output deriv_valid,
        output deriv_in,
        output integ_sum
    );
endinterface

// File: rtl/euler_step_sequencer.sv
// rtl/euler_step_sequencer.sv - Euler substep sequencer around the float integrator; optional EULER_NONFINITE_GUARD_EN
module euler_step_sequencer #(
    parameter int NSTEPS = 1024,
    parameter int CNT_W  = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 init_load,
    input  logic [31:0]          init_value,
    euler_step_sequencer_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     step_count,
    output logic                 ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } fsm_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NSTEPS - 1);

    fsm_t             cur_st;
    fsm_t             nxt_st;
    logic [31:0]      state_q;
    logic [31:0]      x_q;
    logic [CNT_W-1:0] cnt_q;
    logic             run_start;
    logic             sum_nonfinite;

    // init_load wins over start when both arrive in IDLE
    assign run_start = (cur_st == IDLE) && start && !init_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_st <= IDLE;
        end else begin
            cur_st <= nxt_st;
        end
    end

    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            IDLE:    if (run_start) nxt_st = REQ;
            REQ:     if (bus.deriv_valid) nxt_st = ACC;
            ACC:     nxt_st = (cnt_q == LAST_STEP) ? DONE : REQ;
            DONE:    nxt_st = IDLE;
            default: nxt_st = IDLE;
        endcase
    end

`ifdef EULER_NONFINITE_GUARD_EN
    logic ovf_q;

    assign sum_nonfinite = &bus.integ_sum[30:23];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else if (run_start) begin
            ovf_q <= 1'b0;
        end else if ((cur_st == ACC) && sum_nonfinite) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign sum_nonfinite = 1'b0;
    assign ovf           = 1'b0;
`endif

    // Integrator sees state_q and x_q during ACC; its sum closes the loop at the ACC edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= 32'h0000_0000;
            x_q     <= 32'h0000_0000;
            cnt_q   <= '0;
        end else begin
            case (cur_st)
                IDLE: begin
                    if (init_load) begin
                        state_q <= init_value;
                    end else if (start) begin
                        cnt_q <= '0;
                    end
                end
                REQ: begin
                    if (bus.deriv_valid) begin
                        x_q <= bus.deriv_in;
                    end
                end
                ACC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (!sum_nonfinite) begin
                        state_q <= bus.integ_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.state_out = state_q;
    assign bus.integ_x   = x_q;
    assign bus.deriv_req = (cur_st == REQ);
    assign busy          = (cur_st == REQ) || (cur_st == ACC);
    assign done          = (cur_st == DONE);
    assign step_count    = cnt_q;

endmodule
